wb_port_sequencer: RTL and testbench

- Write-back controller for the SEQ Y86-64 core.
- Takes one retiring instruction at a time (icode, cnd, dstE, dstM, valE, valM) and serialises its up-to-two register writes onto the single write port of the register file.
- Handles instructions that write two registers (popq) and the conditional-move squash.
- Sits between the memory stage and the register file; sequences the write port so the register file needs only one port.

---
 rtl/y86_pkg.sv | 33 +++
 rtl/wb_port_sequencer.sv | 160 ++++++++++++++++
 tb/tb_wb_port_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the SEQ Y86-64 back-end blocks.
//   - icode constants (HALT .. POPQ)
//   - register ids RNONE (no destination) and RRSP (stack pointer)
//   - wb_state_t, the state encoding of the write-back sequencer
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Highest legal icode; anything above it retires as an error.
    localparam logic [3:0] ICODE_MAX    = ICODE_POPQ;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_E   = 2'd1,
        WR_M   = 2'd2,
        RETIRE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_port_sequencer.sv
// wb_port_sequencer: write-back controller for the SEQ Y86-64 core.
// Accepts one retiring instruction at a time and serialises its E and M
// register writes onto the register file's single write port (E first,
// then M, so popq %rsp leaves %rsp = valM).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake
//   in_icode, in_cnd    instruction code, condition result (cmov squash)
//   in_dstE/in_dstM     destination register ids (RNONE = none)
//   in_valE/in_valM     ALU and memory results
//   rf_we/addr/data     register-file write port (combinational decode)
//   wb_done             pulse in the last cycle of each instruction
//   wb_err              pulse with wb_done when an illegal icode retires
//
// Handshake: an instruction is taken on any rising clk edge where
// in_valid && in_ready. in_ready is high in IDLE and in the last cycle of
// the instruction in progress, so back-to-back instructions flow with no
// bubble. Inputs are sampled only at that edge.
//
// Build option WB_ELIDE_EN: when both writes target the same register,
// the E write is dropped at accept and only the M write is performed.
module wb_port_sequencer
    import y86_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic              in_cnd,
    input  logic [ADDR_W-1:0] in_dstE,
    input  logic [ADDR_W-1:0] in_dstM,
    input  logic [DATA_W-1:0] in_valE,
    input  logic [DATA_W-1:0] in_valM,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              wb_done,
    output logic              wb_err
);

    localparam logic [ADDR_W-1:0] REG_NONE = ADDR_W'(RNONE);

    wb_state_t         state_q, state_d;
    logic [3:0]        icode_q, icode_d;
    logic [ADDR_W-1:0] dst_e_q, dst_e_d;
    logic [ADDR_W-1:0] dst_m_q, dst_m_d;
    logic [DATA_W-1:0] val_e_q, val_e_d;
    logic [DATA_W-1:0] val_m_q, val_m_d;
    logic              pend_m_q, pend_m_d;

    logic      accept;
    logic      last_cycle;
    logic      in_legal;
    logic      pend_e_in;
    logic      pend_m_in;
    wb_state_t first_state;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            icode_q  <= '0;
            dst_e_q  <= '0;
            dst_m_q  <= '0;
            val_e_q  <= '0;
            val_m_q  <= '0;
            pend_m_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            icode_q  <= icode_d;
            dst_e_q  <= dst_e_d;
            dst_m_q  <= dst_m_d;
            val_e_q  <= val_e_d;
            val_m_q  <= val_m_d;
            pend_m_q <= pend_m_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // Last cycle of an instruction: WR_E only when no M write follows.
        last_cycle = (state_q == WR_M) || (state_q == RETIRE) ||
                     ((state_q == WR_E) && !pend_m_q);
        accept     = in_valid && in_ready;

        in_legal  = (in_icode <= ICODE_MAX);
        pend_e_in = (in_dstE != REG_NONE) && in_legal &&
                    !((in_icode == ICODE_CMOVXX) && !in_cnd);
        pend_m_in = (in_dstM != REG_NONE) && in_legal;
`ifdef WB_ELIDE_EN
        // Same target twice: the M write would overwrite E anyway.
        if (pend_e_in && pend_m_in && (in_dstE == in_dstM)) begin
            pend_e_in = 1'b0;
        end
`endif

        if (pend_e_in) begin
            first_state = WR_E;
        end else if (pend_m_in) begin
            first_state = WR_M;
        end else begin
            first_state = RETIRE;
        end

        state_d  = state_q;
        icode_d  = icode_q;
        dst_e_d  = dst_e_q;
        dst_m_d  = dst_m_q;
        val_e_d  = val_e_q;
        val_m_d  = val_m_q;
        pend_m_d = pend_m_q;

        if ((state_q == WR_E) && pend_m_q) begin
            state_d = WR_M;
        end else if (accept) begin
            state_d  = first_state;
            icode_d  = in_icode;
            dst_e_d  = in_dstE;
            dst_m_d  = in_dstM;
            val_e_d  = in_valE;
            val_m_d  = in_valM;
            pend_m_d = pend_m_in;
        end else if (last_cycle) begin
            state_d = IDLE;
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        in_ready = rst_n && ((state_q == IDLE) || last_cycle);
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_data  = '0;
        wb_done  = last_cycle;
        wb_err   = 1'b0;
        case (state_q)
            WR_E: begin
                rf_we   = 1'b1;
                rf_addr = dst_e_q;
                rf_data = val_e_q;
            end
            WR_M: begin
                rf_we   = 1'b1;
                rf_addr = dst_m_q;
                rf_data = val_m_q;
            end
            RETIRE: begin
                wb_err = (icode_q > ICODE_MAX);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Directed bench for wb_port_sequencer. Inputs change 1 time unit after
// the rising edge; outputs are checked at that same point, after the
// combinational decode of the new state has settled.
// Honours WB_ELIDE_EN for the popq %rsp case.
module tb_wb_port_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic        in_cnd;
    logic [3:0]  in_dstE;
    logic [3:0]  in_dstM;
    logic [63:0] in_valE;
    logic [63:0] in_valM;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data;
    logic        wb_done;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    wb_port_sequencer #(.ADDR_W(4), .DATA_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_icode (in_icode),
        .in_cnd   (in_cnd),
        .in_dstE  (in_dstE),
        .in_dstM  (in_dstM),
        .in_valE  (in_valE),
        .in_valM  (in_valM),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .wb_done  (wb_done),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every output of the write port and status lines at once.
    task automatic check_out(input string tag, input logic rdy,
                             input logic we, input logic [3:0] addr,
                             input logic [63:0] data, input logic done,
                             input logic err);
        check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        check({tag, ".rf_we"},    64'(rf_we),    64'(we));
        if (we) begin
            check({tag, ".rf_addr"}, 64'(rf_addr), 64'(addr));
            check({tag, ".rf_data"}, rf_data,      data);
        end
        check({tag, ".wb_done"},  64'(wb_done),  64'(done));
        check({tag, ".wb_err"},   64'(wb_err),   64'(err));
    endtask

    task automatic present(input logic [3:0] icode, input logic cnd,
                           input logic [3:0] dst_e, input logic [3:0] dst_m,
                           input logic [63:0] val_e, input logic [63:0] val_m);
        in_valid = 1'b1;
        in_icode = icode;
        in_cnd   = cnd;
        in_dstE  = dst_e;
        in_dstM  = dst_m;
        in_valE  = val_e;
        in_valM  = val_m;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_icode = 4'h0;
        in_cnd   = 1'b0;
        in_dstE  = 4'hF;
        in_dstM  = 4'hF;
        in_valE  = '0;
        in_valM  = '0;

        // Reset state.
        #2;
        check_out("reset", 1'b0, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        check("reset.rf_addr", 64'(rf_addr), 64'h0);
        check("reset.rf_data", rf_data, 64'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check_out("idle", 1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);

        // irmovq: one E write the cycle after accept.
        present(4'h3, 1'b0, 4'h2, 4'hF, 64'h1234, 64'hDEAD);
        tick();
        in_valid = 1'b0;
        check_out("irmovq.wr", 1'b1, 1'b1, 4'h2, 64'h1234, 1'b1, 1'b0);
        tick();
        check_out("irmovq.idle", 1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);

        // popq %rbx: E then M, not ready during the E write.
        present(4'hB, 1'b0, 4'h4, 4'h3, 64'h108, 64'hAB);
        tick();
        // These changes arrive while in_ready=0 and must be ignored.
        in_valE = 64'hBAD;
        in_valM = 64'hBAD;
        in_dstM = 4'h7;
        in_valid = 1'b0;
        check_out("popq_rbx.e", 1'b0, 1'b1, 4'h4, 64'h108, 1'b0, 1'b0);
        tick();
        check_out("popq_rbx.m", 1'b1, 1'b1, 4'h3, 64'hAB, 1'b1, 1'b0);
        tick();
        check_out("popq_rbx.idle", 1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);

        // popq %rsp: final write of r4 is valM in both builds.
        present(4'hB, 1'b0, 4'h4, 4'h4, 64'h108, 64'h55);
        tick();
        in_valid = 1'b0;
`ifdef WB_ELIDE_EN
        check_out("popq_rsp.m", 1'b1, 1'b1, 4'h4, 64'h55, 1'b1, 1'b0);
`else
        check_out("popq_rsp.e", 1'b0, 1'b1, 4'h4, 64'h108, 1'b0, 1'b0);
        tick();
        check_out("popq_rsp.m", 1'b1, 1'b1, 4'h4, 64'h55, 1'b1, 1'b0);
`endif
        tick();
        check_out("popq_rsp.idle", 1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);

        // cmov squashed: RETIRE, no write.
        present(4'h2, 1'b0, 4'h5, 4'hF, 64'h77, 64'h0);
        tick();
        check_out("cmov_sq", 1'b1, 1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
        // cmov taken, accepted in the RETIRE cycle (no bubble).
        present(4'h2, 1'b1, 4'h5, 4'hF, 64'h77, 64'h0);
        tick();
        check_out("cmov_tk", 1'b1, 1'b1, 4'h5, 64'h77, 1'b1, 1'b0);

        // Back-to-back irmovq, rrmovq, illegal icode.
        present(4'h3, 1'b0, 4'h1, 4'hF, 64'h11, 64'h0);
        tick();
        check_out("b2b.irmovq", 1'b1, 1'b1, 4'h1, 64'h11, 1'b1, 1'b0);
        present(4'h2, 1'b1, 4'h6, 4'hF, 64'h22, 64'h0);
        tick();
        check_out("b2b.rrmovq", 1'b1, 1'b1, 4'h6, 64'h22, 1'b1, 1'b0);
        present(4'hC, 1'b1, 4'h1, 4'h2, 64'h33, 64'h44);
        tick();
        in_valid = 1'b0;
        check_out("b2b.illegal", 1'b1, 1'b0, 4'h0, 64'h0, 1'b1, 1'b1);
        tick();
        check_out("b2b.idle", 1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);

        // nop: RETIRE, no error.
        present(4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        tick();
        in_valid = 1'b0;
        check_out("nop", 1'b1, 1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
        tick();

        // Reset during the E write of popq: M write is dropped.
        present(4'hB, 1'b0, 4'h4, 4'h3, 64'h108, 64'hAB);
        tick();
        in_valid = 1'b0;
        check_out("rst_mid.e", 1'b0, 1'b1, 4'h4, 64'h108, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid.low", 1'b0, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check_out("rst_mid.rel", 1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        check("rst_mid.rf_addr", 64'(rf_addr), 64'h0);
        check("rst_mid.rf_data", rf_data, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("rst_mid.after", 1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
